// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, state type and address helpers for register_bank_mp
package rf_pkg;
  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  typedef enum logic {INIT, RUN} rf_state_t;
  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction
  // bit r set when r is a writable architectural register (1..n-1)
  function automatic logic [63:0] rf_valid(input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 1; i < n && i < 64; i++) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/register_bank_mp_if.sv
// register_bank_mp_if: decode/writeback-facing bus of the register bank
interface register_bank_mp_if
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2,
  localparam int AW   = rf_aw(NREGS)
) ();
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                init_req;
  logic                ready;
  modport master (output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, init_req,
                  input rd_data, rd_busy, ready);
  modport slave  (input rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, init_req,
                  output rd_data, rd_busy, ready);
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with same-cycle release masking on the read ports
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              set_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic              rel_i,
  input  logic [AW-1:0]     rel_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
);
  localparam int NA = 1 << AW;
  localparam logic [NA-1:0] VALID = NA'(rf_valid(NREGS));
  logic [NA-1:0] busy_q, busy_d;
  // release first, then reserve, so a same-cycle reservation wins; r0 and out-of-range never set
  always_comb busy_d = clr_i ? '0 : ((busy_q & ~(rel_i ? NA'(1) << rel_addr_i : '0))
                                    | (set_i ? NA'(1) << set_addr_i : '0)) & VALID;
  // busy vector register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  for (genvar k = 0; k < NRD; k++) begin : g_port
    assign rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]] && !(rel_i && rel_addr_i == rd_addr_i[k*AW +: AW]);
  end
endmodule

// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-read-port register file with write bypass, busy scoreboard and scrub FSM
module register_bank_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2
) (
  input logic clk,
  input logic rst_n,
  register_bank_mp_if.slave bus
);
  localparam int AW = rf_aw(NREGS);
  localparam int NA = 1 << AW;
  localparam logic [NA-1:0] VALID = NA'(rf_valid(NREGS));
  rf_state_t state_q;
  logic [AW-1:0] cnt_q;
  logic ready_q;
  logic [XLEN-1:0] mem [NA];
  logic run, wr_ok;
  assign run   = state_q == RUN;
  assign wr_ok = run && bus.wr_en && VALID[bus.wr_addr];
  // scrub sequencer: INIT walks the counter over 1..NREGS-1, RUN waits for a scrub request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS - 1)) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end else if (bus.init_req) begin
      state_q <= INIT;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end
  // storage has no reset so it can map to distributed RAM; the scrub supplies the zeros
  always_ff @(posedge clk)
    if (state_q == INIT) mem[cnt_q] <= '0;
    else if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.rd_addr[k*AW +: AW];
    assign bus.rd_data[k*XLEN +: XLEN] = !(run && VALID[a]) ? '0
                                       : (bus.wr_en && bus.wr_addr == a) ? bus.wr_data : mem[a];
  end
  rf_scoreboard #(.NREGS(NREGS), .NRD(NRD), .AW(AW)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (!run || bus.init_req),
    .set_i      (run && bus.rsv_en),
    .set_addr_i (bus.rsv_addr),
    .rel_i      (run && bus.wr_en),
    .rel_addr_i (bus.wr_addr),
    .rd_addr_i  (bus.rd_addr),
    .rd_busy_o  (bus.rd_busy)
  );
  assign bus.ready = ready_q;
endmodule

// File: doc/register_bank_mp.md
# register_bank_mp

Parametrised multi-read-port integer register file, the successor to the single-configuration register bank in the R-type datapath. It adds:
- configurable width, depth and read-port count;
- same-cycle write-to-read bypass;
- a per-register busy scoreboard for the pipeline's hazard logic;
- a sequential scrub FSM that clears storage after reset or on request.

Storage has no reset, so it can map to distributed RAM. It sits between decode (read addresses, reservations) and writeback (write port).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (2..64); register 0 is hardwired to zero
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), address width (derived; not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational
- rd_busy  out  NRD  per-port scoreboard busy flag, combinational
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- rsv_en  in  1  reserve (mark busy) strobe
- rsv_addr  in  AW  register to reserve
- init_req  in  1  single-cycle pulse that requests a scrub
- ready  out  1  high when in RUN

## Operation
- FSM states: INIT, RUN.
  - rst_n low: state forced to INIT, scrub counter set to 1, all busy bits cleared, ready=0.
  - INIT: each cycle writes 0 to storage[counter] and increments the counter. When counter == NREGS-1 is written, next state is RUN.
  - RUN: init_req=1 moves to INIT with counter=1 and clears all busy bits. init_req is ignored in INIT.
- During INIT:
  - wr_en and rsv_en are ignored.
  - rd_data reads 0 and rd_busy reads 0.
- Read in RUN, per port k, in priority order:
  1. addr==0 or addr>=NREGS: data 0.
  2. wr_en && wr_addr==addr: data = wr_data (bypass).
  3. Otherwise: data = storage[addr].
- Write in RUN: wr_en with 0 < wr_addr < NREGS stores wr_data on the clock edge. Writes to address 0 or to out-of-range addresses are dropped.
- Scoreboard in RUN, one busy bit per register; busy[0] is constant 0.
  - rsv_en sets busy[rsv_addr].
  - wr_en clears busy[wr_addr].
  - Reserve and write to the same address in the same cycle: the bit stays set (the new reservation wins).
  - Out-of-range rsv_addr is ignored.
- rd_busy[k] = busy[addr] && !(wr_en && wr_addr==addr), so a port is seen not busy in the same cycle as the write that releases it.

## Timing
- Reset values: ready=0; rd_data all 0; rd_busy all 0; state INIT; busy all 0.
- Scrub length:
  - Exactly NREGS-1 cycles after the first clk edge with rst_n high.
  - ready rises after the edge that writes register NREGS-1.
  - Example: NREGS=32 gives 31 cycles.
- Read latency 0 (combinational). Write latency 1 edge; bypass covers the write cycle itself.
- Scoreboard updates become visible 1 edge after rsv_en or wr_en, except for the same-cycle release masking on rd_busy.
- init_req in RUN: ready falls after the same edge; a wr_en in that same cycle is still committed.
- rst_n asserted mid-scrub or mid-operation: INIT restarts immediately and ready=0 asynchronously. Storage contents are undefined until the scrub completes.

## Structure
- Package rf_pkg holds:
  - default XLEN and NREGS constants;
  - rf_state_t enum {INIT, RUN};
  - a function that computes AW.
- One natural sub-module, rf_scoreboard. It holds the busy-bit vector, the set/clear priority and the per-port rd_busy masking, and is parameterised by NREGS, NRD and AW.
- Storage array, scrub FSM, counter and bypass muxes stay in the top module.

## Test plan
- Reset, NREGS=32: release rst_n and count cycles -> ready=0 for exactly 31 cycles, then 1. rd_data is 0 on every port throughout.
- Write and read: write 0xDEADBEEF to r5, then read r5 on both ports -> 0xDEADBEEF on the next cycle. Write 0x1234 to r0 -> r0 still reads 0.
- Bypass: wr_en to r7 with 0xA5A5A5A5 while port 1 reads r7 in the same cycle -> rd_data port 1 = 0xA5A5A5A5 in that cycle; stored value is old data before the edge and new data after.
- Scoreboard:
  - rsv r9, then read r9 -> rd_busy=1.
  - Write r9 -> rd_busy=0 in the write cycle and stays 0.
  - rsv and wr to r9 in the same cycle -> rd_busy=1 afterwards.
- Re-scrub: init_req in RUN with r3=0x55 and r3 busy -> ready=0 for 31 cycles, wr_en ignored during INIT, then r3 reads 0 and rd_busy=0.
- Async reset mid-scrub: assert rst_n low at scrub cycle 10 -> ready stays 0 and the full 31-cycle scrub restarts after release. Repeat with NREGS=16, NRD=3 -> 15-cycle scrub and all three ports correct.
